fft16_output_reorder: RTL
=========================

// Module: fft16_output_reorder
// PURPOSE
//  Sits directly downstream of the 16-point radix-4 FFT second stage and consumes its 16 parallel
//  complex outputs. Captures each frame into a ping-pong buffer, undoes the radix-4 digit-reversed
//  ordering, and streams one complex bin per clock to the envelope/magnitude logic over valid/ready.
//  The FFT stages have no backpressure, so a frame that arrives while both banks are full is dropped
//  and flagged.
// PARAMETERS
//  DW       16  bit width of each re/im sample (two's complement, Q1.15 as produced by the FFT)
//  NPT      16  points per frame; fixed at 16 (4-bit bin index)
//  DIGITREV 1   1: bin k read from bus slot {k[1:0],k[3:2]}; 0: bin k read from slot k (bypass)
// PORTS
//  clk       in   1        system clock, all logic on rising edge
//  rst       in   1        synchronous reset, active-high
//  in_valid  in   1        frame strobe, aligned with the FFT 2nd-stage outputs
//  in_re     in   NPT*DW   slot s at [s*DW +: DW] = butterfly_re<s>
//  in_im     in   NPT*DW   slot s at [s*DW +: DW] = butterfly_im<s>
//  in_ready  out  1        write bank empty; frame accepted when in_valid & in_ready
//  out_valid out  1        out_re/out_im/out_idx/out_last valid
//  out_ready in   1        downstream accepts the current bin
//  out_re    out  DW       real part of bin out_idx
//  out_im    out  DW       imaginary part of bin out_idx
//  out_idx   out  4        natural-order bin index 0..15
//  out_last  out  1        high with bin 15
//  drop      out  1        sticky: a frame arrived with in_ready=0
// BEHAVIOUR
//  - Reset: both banks empty, wr_ptr=0, rd_ptr=0, bin counter=0. in_ready=1, out_valid=0,
//    out_idx=0, out_last=0, drop=0, out_re/out_im=0. Bank data is not cleared.
//  - Capture: on in_valid & in_ready, latch all 32 words into bank[wr_ptr], set full[wr_ptr],
//    toggle wr_ptr. in_ready = ~full[wr_ptr], taken from registered state only. It has no
//    combinational path from out_ready.
//  - Drop: on in_valid & ~in_ready, discard the frame and set drop. drop clears only on rst.
//  - Read FSM:
//    - IDLE: out_valid=0. Go to STREAM when full[rd_ptr].
//    - STREAM: out_valid=1, bin cnt 0..15.
//    - A beat transfers when out_valid & out_ready. Each beat increments cnt.
//    - The beat with cnt=15 clears full[rd_ptr], toggles rd_ptr, sets cnt=0. Next state is STREAM
//      if the other bank is full (no bubble), otherwise IDLE.
//  - Latency: frame captured at edge N gives out_valid=1 with out_idx=0 after edge N+1. Best-case
//    throughput is one frame per 16 cycles.
//  - Stall: while out_valid & ~out_ready, all out_* hold stable.
//  - Data: out_re/out_im = bank[rd_ptr] slot perm(cnt), muxed from registers. No arithmetic and no
//    width change.
//  - Simultaneous capture and release in the same cycle:
//    - Capture writes bank[wr_ptr], which was empty at the start of the cycle.
//    - Release frees bank[rd_ptr] at the end of the cycle.
//    - Both take effect, and the freed bank shows in_ready=1 from the next cycle.
//  - Reset mid-frame: the partial stream is abandoned, all frames are lost, and the block returns
//    to the reset state. Downstream must tolerate out_last never arriving for that frame.
// STRUCTURE
//  - fft16_defs.vh: NPT, DW, slot-packing macros, function digit_rev4(k) = {k[1:0],k[3:2]}.
//    Shared with the FFT stage wrappers.
//  - Sub-module fft16_frame_bank: one 2*NPT*DW register bank with a load enable and a 4-bit read
//    slot select. Instantiated twice.
//  - The top level holds the ptrs, full flags, read FSM and drop flag.
// TESTING
//  - Single frame, out_ready=1: slot s re=s, im=0x100+s, DIGITREV=1
//    -> bins 0..15 carry re 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15;
//    -> out_valid 16 consecutive cycles starting one cycle after capture; out_last only on idx 15.
//  - Back-to-back frames A,B one cycle apart, out_ready=1
//    -> 32 contiguous beats, A then B, no gap at the A15->B0 boundary.
//  - Three frames, out_ready=0 -> frames 1,2 accepted; in_ready=0 at frame 3; drop=1.
//    Then release out_ready -> exactly 32 beats (frames 1 and 2).
//  - Random out_ready (50%) -> outputs hold while stalled; the bin sequence matches the golden
//    reorder model; re=0x8000 and 0x7FFF pass through bit-exact.
//  - rst asserted at bin 7 -> next cycle out_valid=0, in_ready=1, drop=0.
//    A new frame then streams from idx 0.
//  - DIGITREV=0 -> bin k = slot k for a ramp input.

Source files
------------

// File: rtl/fft16_output_reorder_pkg.sv
// Shared constants, read-FSM state type and the radix-4 digit-reversal helper
// for the 16-point FFT output reorder block.
package fft16_output_reorder_pkg;

  localparam int NPT    = 16;
  localparam int DW_DEF = 16;
  localparam int IDXW   = 4;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // Radix-4 digit reversal of a 4-bit bin index: swap the two base-4 digits.
  function automatic logic [IDXW-1:0] digit_rev4(input logic [IDXW-1:0] k);
    return {k[1:0], k[3:2]};
  endfunction

endpackage

// File: rtl/fft16_output_reorder_if.sv
// Frame-in / bin-out bus of the FFT output reorder block.
// The slave side is the reorder block; the master side is its environment.
interface fft16_output_reorder_if
  import fft16_output_reorder_pkg::*;
  #(parameter int DW = DW_DEF);

  logic              in_valid;
  logic [NPT*DW-1:0] in_re;
  logic [NPT*DW-1:0] in_im;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_re;
  logic [DW-1:0]     out_im;
  logic [IDXW-1:0]   out_idx;
  logic              out_last;
  logic              drop;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, drop
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, drop
  );

endinterface

// File: rtl/fft16_frame_bank.sv
// One frame of 16 complex samples held in registers, loaded in parallel and
// read one slot at a time through a 4-bit select.
module fft16_frame_bank
  import fft16_output_reorder_pkg::*;
  #(parameter int DW = DW_DEF)
  (
    input  logic              clk,
    input  logic              load_i,
    input  logic [NPT*DW-1:0] re_i,
    input  logic [NPT*DW-1:0] im_i,
    input  logic [IDXW-1:0]   sel_i,
    output logic [DW-1:0]     re_o,
    output logic [DW-1:0]     im_o
  );

  // Data storage is intentionally not reset; the full flags qualify it.
  logic [DW-1:0] re_q [NPT];
  logic [DW-1:0] im_q [NPT];

  always_ff @(posedge clk) begin
    if (load_i) begin
      for (int s = 0; s < NPT; s++) begin
        re_q[s] <= re_i[s*DW +: DW];
        im_q[s] <= im_i[s*DW +: DW];
      end
    end
  end

  assign re_o = re_q[sel_i];
  assign im_o = im_q[sel_i];

endmodule

// File: rtl/fft16_output_reorder.sv
// Ping-pong capture of parallel FFT frames and natural-order streaming of the
// 16 bins over valid/ready; frames arriving with both banks full are dropped.
module fft16_output_reorder
  import fft16_output_reorder_pkg::*;
  #(
    parameter int DW       = DW_DEF,
    parameter bit DIGITREV = 1'b1
  )
  (
    input logic                   clk,
    input logic                   rst,
    fft16_output_reorder_if.slave bus
  );

  rd_state_e       state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic            drop_q;

  logic            cap, beat, rel, stream;
  logic            load0, load1;
  logic [IDXW-1:0] slot;
  logic [DW-1:0]   re0, im0, re1, im1;

  // in_ready depends on registered state only, never on out_ready.
  assign bus.in_ready = ~full_q[wr_ptr_q];
  assign cap    = bus.in_valid & ~full_q[wr_ptr_q];
  assign stream = (state_q == RD_STREAM);
  assign beat   = stream & bus.out_ready;
  assign rel    = beat & (cnt_q == 4'hF);
  assign load0  = cap & ~wr_ptr_q;
  assign load1  = cap & wr_ptr_q;
  assign slot   = DIGITREV ? digit_rev4(cnt_q) : cnt_q;

  fft16_frame_bank #(.DW(DW)) u_bank0 (
    .clk(clk), .load_i(load0), .re_i(bus.in_re), .im_i(bus.in_im),
    .sel_i(slot), .re_o(re0), .im_o(im0)
  );

  fft16_frame_bank #(.DW(DW)) u_bank1 (
    .clk(clk), .load_i(load1), .re_i(bus.in_re), .im_i(bus.in_im),
    .sel_i(slot), .re_o(re1), .im_o(im1)
  );

  assign bus.out_valid = stream;
  assign bus.out_re    = stream ? (rd_ptr_q ? re1 : re0) : '0;
  assign bus.out_im    = stream ? (rd_ptr_q ? im1 : im0) : '0;
  assign bus.out_idx   = cnt_q;
  assign bus.out_last  = stream & (cnt_q == 4'hF);
  assign bus.drop      = drop_q;

  // Capture and release never target the same bank: one is empty, one is full.
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    if (cap) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (rel) full_d[rd_ptr_q] = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_ptr_q]) state_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (beat) begin
          cnt_d = cnt_q + 4'd1;
          if (rel) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = '0;
            state_d  = full_q[~rd_ptr_q] ? RD_STREAM : RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RD_IDLE;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_q | (bus.in_valid & full_q[wr_ptr_q]);
    end
  end

endmodule
